// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small input FIFO.
// Bytes are pushed through a valid/ready handshake, buffered, and serialised
// LSB-first (start bit, 8 data bits, stop bit). Frames go out back-to-back
// while the FIFO holds data.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   send   - byte-valid strobe
//   data   - byte to transmit, captured on the accepting edge
//   ready  - FIFO can accept a byte (count < FIFO_DEPTH)
//   tx     - serial line, idles high
//   busy   - frame in progress or bytes buffered
//   done   - one-cycle pulse on the last clock of each stop bit
module uart_tx #(
    parameter int unsigned CYCLES_PER_BIT = 10400,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(CYCLES_PER_BIT);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_PRE  = BIT_W'(CYCLES_PER_BIT - 2);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic             push_c;
    logic             pop_c;
    logic             bit_end_c;
    logic             idle_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Handshake, pop decision and next-cycle FIFO occupancy.
    always_comb begin
        push_c      = send && ready;
        bit_end_c   = (bit_cnt == BIT_LAST);
        pop_c       = (count != '0) &&
                      ((state == IDLE) || ((state == STOP) && bit_end_c));
        idle_nxt_c  = (count == '0) &&
                      ((state == IDLE) || ((state == STOP) && bit_end_c));
        count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, occupancy, and the registered ready/busy flags.
    // ready/busy are loaded with the values implied by the next count/state,
    // so they track the registered state exactly with no combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            ready <= (count_nxt_c < FULL);
            busy  <= !(idle_nxt_c && (count_nxt_c == '0));
        end
    end

    // Frame FSM: bit timing, shift register and the registered tx/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    if (pop_c) begin
                        shift   <= mem[rd_ptr];
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        if (bit_idx != 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end else begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        if (pop_c) begin
                            // Next byte starts immediately: no idle bit between frames.
                            shift   <= mem[rd_ptr];
                            bit_idx <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        // Registered one cycle ahead so it lands on the last stop clock.
                        done    <= (bit_cnt == BIT_PRE);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CYCLES_PER_BIT=4,
// FIFO_DEPTH=4. Outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] data;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CYCLES_PER_BIT(CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .send (send),
        .data (data),
        .ready(ready),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at sample i (0-based) of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int j;
        j = i / CPB;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Check tx and done on every clock of samples first..FRAME-1 of a frame.
    task automatic frame(input logic [7:0] b, input int first, input string tag);
        for (int i = first; i < FRAME; i++) begin
            tick();
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(exp_bit(b, i)));
            chk($sformatf("%s_done%0d", tag, i), 32'(done), 32'(i == FRAME - 1));
        end
    endtask

    task automatic idle_chk(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'd1);
            chk($sformatf("%s_done%0d", tag, i), 32'(done), 32'd0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd0);
            chk($sformatf("%s_ready%0d", tag, i), 32'(ready), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        send  = 1'b0;
        data  = 8'h00;

        // Reset then idle.
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        idle_chk(50, "idle");

        // Single byte 0xA5; start bit begins one edge after acceptance.
        send = 1'b1;
        data = 8'hA5;
        tick();
        send = 1'b0;
        data = 8'h00;
        chk("a5_tx_accept", 32'(tx), 32'd1);
        chk("a5_busy_accept", 32'(busy), 32'd1);
        frame(8'hA5, 0, "a5");
        chk("a5_busy_last", 32'(busy), 32'd1);
        idle_chk(5, "a5_after");

        // Burst of five on consecutive cycles; fifth fits because the first popped.
        send = 1'b1;
        data = 8'h00;
        tick();
        chk("burst_rdy0", 32'(ready), 32'd1);
        data = 8'hFF;
        tick();
        chk("burst_rdy1", 32'(ready), 32'd1);
        chk("burst_tx0", 32'(tx), 32'd0);
        data = 8'h55;
        tick();
        chk("burst_rdy2", 32'(ready), 32'd1);
        data = 8'h0F;
        tick();
        chk("burst_rdy3", 32'(ready), 32'd1);
        data = 8'h81;
        tick();
        chk("burst_rdy4", 32'(ready), 32'd0);
        send = 1'b0;
        frame(8'h00, 4, "b00");
        frame(8'hFF, 0, "bff");
        frame(8'h55, 0, "b55");
        frame(8'h0F, 0, "b0f");
        frame(8'h81, 0, "b81");
        idle_chk(5, "burst_after");

        // FIFO full: 0xEE offered while ready=0 must be dropped.
        send = 1'b1;
        data = 8'h11;
        tick();
        data = 8'h22;
        tick();
        data = 8'h33;
        tick();
        data = 8'h44;
        tick();
        data = 8'h55;
        tick();
        chk("full_rdy", 32'(ready), 32'd0);
        data = 8'hEE;
        tick();
        chk("full_rdy_drop", 32'(ready), 32'd0);
        send = 1'b0;
        data = 8'h00;
        frame(8'h11, 5, "f11");
        chk("full_rdy_before_pop", 32'(ready), 32'd0);
        tick();
        chk("full_rdy_after_pop", 32'(ready), 32'd1);
        chk("f22_tx0", 32'(tx), 32'd0);
        frame(8'h22, 1, "f22");
        frame(8'h33, 0, "f33");
        frame(8'h44, 0, "f44");
        frame(8'h55, 0, "f55");
        idle_chk(12, "full_after");

        // Push on the same edge as the STOP->START pop with count=1.
        send = 1'b1;
        data = 8'h3C;
        tick();
        data = 8'h96;
        tick();
        send = 1'b0;
        data = 8'h00;
        chk("sim_tx0", 32'(tx), 32'd0);
        frame(8'h3C, 1, "s3c");
        send = 1'b1;
        data = 8'h5A;
        tick();
        send = 1'b0;
        data = 8'h00;
        chk("sim_tx_start", 32'(tx), 32'd0);
        chk("sim_rdy", 32'(ready), 32'd1);
        frame(8'h96, 1, "s96");
        frame(8'h5A, 0, "s5a");
        idle_chk(5, "sim_after");

        // Reset during DATA bit 3 with further bytes queued.
        send = 1'b1;
        data = 8'h77;
        tick();
        data = 8'h78;
        tick();
        data = 8'h79;
        tick();
        send = 1'b0;
        data = 8'h00;
        repeat (15) tick();
        chk("mid_tx_bit3", 32'(tx), 32'(exp_bit(8'h77, 17)));
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        idle_chk(50, "mid_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
